// File: rtl/dp_pkg.sv
// dp_pkg: shared enums, status bit positions and sign-extension helper for dp_seq_datapath.
// Latency: n/a (types and functions only).
// Backpressure: n/a. DP_CARRY_EN widens the status word to carry a C bit.
package dp_pkg;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_NOTB = 2'b11} aluop_e;
  typedef enum logic [1:0] {SH_PASS = 2'b00, SH_LSL1 = 2'b01, SH_LSR1 = 2'b10, SH_ASR1 = 2'b11} shift_e;
  typedef enum logic [1:0] {VS_C = 2'b00, VS_PC = 2'b01, VS_IMM8 = 2'b10, VS_MEM = 2'b11} vsel_e;
  typedef enum logic [2:0] {S_IDLE, S_LDA, S_LDB, S_EXEC, S_WB} state_e;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_V = 2;
  localparam int ST_C = 3;

`ifdef DP_CARRY_EN
  localparam int STATUS_W = 4;
`else
  localparam int STATUS_W = 3;
`endif

  localparam int SEXT_W = 64;

  // Sign-extend the low 'width' bits of value to SEXT_W bits; bits above width are ignored.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] value, input int width);
    logic signed [SEXT_W-1:0] t;
    t = value << (SEXT_W - width);
    return t >>> (SEXT_W - width);
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// dp_regfile: NREGS x WIDTH register file, one synchronous write port, two combinational read ports.
// Latency: reads same cycle, write visible the cycle after we.
// Backpressure: none; every write request is taken.
module dp_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RA_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [RA_W-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [RA_W-1:0]  raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [RA_W-1:0]  raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [NREGS];

  // Storage: cleared on reset, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/dp_seq_datapath.sv
// dp_seq_datapath: self-sequencing regfile/shifter/ALU datapath (IDLE->LDA->LDB->EXEC->WB).
// Latency: start accepted at cycle 0, done pulses at cycle 4, register write visible at cycle 5.
// Backpressure: start honoured only in IDLE, dropped while busy. DP_CARRY_EN adds status C bit.
module dp_seq_datapath
  import dp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int PC_W   = 8,
  parameter int IMM5_W = 5,
  parameter int IMM8_W = 8,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic [RA_W-1:0]     rn,
  input  logic [RA_W-1:0]     rm,
  input  logic [RA_W-1:0]     rd,
  input  logic [1:0]          shift,
  input  logic [1:0]          aluop,
  input  logic                asel,
  input  logic                bsel,
  input  logic [1:0]          vsel,
  input  logic                wb_en,
  input  logic                ld_status,
  input  logic [IMM5_W-1:0]   imm5,
  input  logic [IMM8_W-1:0]   imm8,
  input  logic [PC_W-1:0]     pc,
  input  logic [WIDTH-1:0]    mdata,
  output logic [WIDTH-1:0]    dp_out,
  output logic [STATUS_W-1:0] status
);

  typedef struct packed {
    logic [RA_W-1:0]   rn;
    logic [RA_W-1:0]   rm;
    logic [RA_W-1:0]   rd;
    shift_e            shift;
    aluop_e            aluop;
    logic              asel;
    logic              bsel;
    vsel_e             vsel;
    logic              wb_en;
    logic              ld_status;
    logic [IMM5_W-1:0] imm5;
    logic [IMM8_W-1:0] imm8;
    logic [PC_W-1:0]   pc;
  } cmd_t;

  state_e               state, state_nxt;
  cmd_t                 cmd;
  logic [WIDTH-1:0]     a, b, c;
  logic [STATUS_W-1:0]  status_q;
  logic [WIDTH-1:0]     rd_a, rd_b, b_shf, ain, bin, alu_res, wb_dat;
  logic                 alu_v;
  logic                 rf_we;
  logic                 accept;
`ifdef DP_CARRY_EN
  logic                 alu_c;
`endif

  assign accept = (state == S_IDLE) && start;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_WB);
  assign dp_out = c;
  assign status = status_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: only IDLE waits for start, every other step is unconditional.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LDA;
      S_LDA:   state_nxt = S_LDB;
      S_LDB:   state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command capture on acceptance so the controller may move on immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd <= '0;
    end else if (accept) begin
      cmd.rn        <= rn;
      cmd.rm        <= rm;
      cmd.rd        <= rd;
      cmd.shift     <= shift_e'(shift);
      cmd.aluop     <= aluop_e'(aluop);
      cmd.asel      <= asel;
      cmd.bsel      <= bsel;
      cmd.vsel      <= vsel_e'(vsel);
      cmd.wb_en     <= wb_en;
      cmd.ld_status <= ld_status;
      cmd.imm5      <= imm5;
      cmd.imm8      <= imm8;
      cmd.pc        <= pc;
    end
  end

  // Single-bit shifter on the B operand.
  always_comb begin
    b_shf = b;
    case (cmd.shift)
      SH_PASS: b_shf = b;
      SH_LSL1: b_shf = {b[WIDTH-2:0], 1'b0};
      SH_LSR1: b_shf = {1'b0, b[WIDTH-1:1]};
      SH_ASR1: b_shf = {b[WIDTH-1], b[WIDTH-1:1]};
      default: b_shf = b;
    endcase
  end

  assign ain = cmd.asel ? '0 : a;
  assign bin = cmd.bsel ? WIDTH'(sext(SEXT_W'(cmd.imm5), IMM5_W)) : b_shf;

  // ALU with signed-overflow flag; carry path only exists when DP_CARRY_EN is set.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
`ifdef DP_CARRY_EN
    alu_c   = 1'b0;
`endif
    case (cmd.aluop)
      ALU_ADD: begin
`ifdef DP_CARRY_EN
        {alu_c, alu_res} = {1'b0, ain} + {1'b0, bin};
`else
        alu_res = ain + bin;
`endif
        alu_v = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      ALU_SUB: begin
`ifdef DP_CARRY_EN
        // Top bit of 2^WIDTH + a - b is 1 exactly when no borrow occurs.
        {alu_c, alu_res} = {1'b1, ain} - {1'b0, bin};
`else
        alu_res = ain - bin;
`endif
        alu_v = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      ALU_AND:  alu_res = ain & bin;
      ALU_NOTB: alu_res = ~bin;
      default:  alu_res = '0;
    endcase
  end

  // Operand latches, result register and status flags, each in its own FSM step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a        <= '0;
      b        <= '0;
      c        <= '0;
      status_q <= '0;
    end else begin
      if (state == S_LDA) a <= rd_a;
      if (state == S_LDB) b <= rd_b;
      if (state == S_EXEC) begin
        c <= alu_res;
        if (cmd.ld_status) begin
          status_q[ST_Z] <= (alu_res == '0);
          status_q[ST_N] <= alu_res[WIDTH-1];
          status_q[ST_V] <= alu_v;
`ifdef DP_CARRY_EN
          status_q[ST_C] <= alu_c;
`endif
        end
      end
    end
  end

  // Writeback source select; mdata is taken live in the WB cycle.
  always_comb begin
    wb_dat = c;
    case (cmd.vsel)
      VS_C:    wb_dat = c;
      VS_PC:   wb_dat = WIDTH'(cmd.pc);
      VS_IMM8: wb_dat = WIDTH'(sext(SEXT_W'(cmd.imm8), IMM8_W));
      VS_MEM:  wb_dat = mdata;
      default: wb_dat = c;
    endcase
  end

  assign rf_we = (state == S_WB) && cmd.wb_en;

  dp_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (cmd.rd),
    .wdata   (wb_dat),
    .raddr_a (cmd.rn),
    .rdata_a (rd_a),
    .raddr_b (cmd.rm),
    .rdata_b (rd_b)
  );

endmodule
